// File: rtl/onn_pkg.sv
// Shared oscillator-network constants, readout FSM states and frame length.
// Frame length depends on PHI_TX_PARITY_EN (appends an even-parity bit).
package onn_pkg;

   localparam int N_NEURON = 15;
   localparam int PHI_W    = 4;
   localparam int VW       = N_NEURON * PHI_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      SHIFT = 2'd2
   } tx_state_e;

   function automatic int frame_len();
`ifdef PHI_TX_PARITY_EN
      return VW + 1;
`else
      return VW;
`endif
   endfunction

   localparam int FRAME_LEN = frame_len();
   localparam int BCNT_W    = $clog2(FRAME_LEN + 1);

endpackage

// File: rtl/phi_stable_filter.sv
// Saturating run-length counter on steady; hit_o marks the cycle whose edge
// completes STABLE_CYC consecutive steady samples while enabled.
module phi_stable_filter #(
   parameter int STABLE_CYC = 4,
   parameter int CNT_W      = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic steady_i,
   output logic hit_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Disabled or a dropped steady restarts the run from zero.
   always_comb begin
      cnt_d = '0;
      if (en_i && steady_i) begin
         cnt_d = (cnt_q == CNT_W'(STABLE_CYC)) ? cnt_q : cnt_q + 1'b1;
      end
   end

   assign hit_o = en_i && steady_i && (cnt_q == CNT_W'(STABLE_CYC - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/phi_readout_tx.sv
// Serial readout of the settled phase vector in bit-plus-load framing.
// PHI_TX_PARITY_EN appends an even-parity bit after the last phase bit.
module phi_readout_tx
   import onn_pkg::*;
#(
   parameter int STABLE_CYC = 4
) (
   input  logic          sclk,
   input  logic          re_n,
   input  logic          tx_req,
   input  logic          steady,
   input  logic          inconsistant,
   input  logic [0:VW-1] phi_in,
   output logic          tx_bit,
   output logic          tx_load,
   output logic          tx_busy,
   output logic          tx_done,
   output logic          tx_err,
   output tx_state_e     state_dbg
);

   tx_state_e         state_q, state_d;
   logic [0:VW-1]     shadow_q, shadow_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic              pend_q, pend_d;
   logic              bit_q, bit_d, load_q, load_d, busy_q, busy_d;
   logic              done_q, done_d, err_q, err_d;
   logic              stable_hit, frame_bit;

   phi_stable_filter #(
      .STABLE_CYC(STABLE_CYC),
      .CNT_W     (4)
   ) u_filter (
      .clk_i   (sclk),
      .rst_ni  (re_n),
      .en_i    (state_q == ARM),
      .steady_i(steady),
      .hit_o   (stable_hit)
   );

   always_comb begin
      frame_bit = 1'b0;
      if (bcnt_q < BCNT_W'(VW)) begin
         frame_bit = shadow_q[bcnt_q];
      end
`ifdef PHI_TX_PARITY_EN
      else begin
         frame_bit = ^shadow_q;
      end
`endif
   end

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      bcnt_d   = bcnt_q;
      pend_d   = pend_q;
      bit_d    = 1'b0;
      load_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      busy_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tx_req) state_d = ARM;
         end
         ARM: begin
            // Inconsistency wins over a capture landing on the same edge.
            if (inconsistant) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (stable_hit) begin
               shadow_d = phi_in;
               bit_d    = phi_in[0];
               load_d   = 1'b1;
               bcnt_d   = BCNT_W'(1);
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            if (bcnt_q == BCNT_W'(FRAME_LEN)) begin
               done_d  = 1'b1;
               bcnt_d  = '0;
               pend_d  = 1'b0;
               state_d = (pend_q || tx_req) ? ARM : IDLE;
            end else begin
               bit_d  = frame_bit;
               load_d = 1'b1;
               bcnt_d = bcnt_q + 1'b1;
               pend_d = pend_q | tx_req;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge sclk or negedge re_n) begin
      if (!re_n) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         bcnt_q   <= '0;
         pend_q   <= 1'b0;
         bit_q    <= 1'b0;
         load_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         bcnt_q   <= bcnt_d;
         pend_q   <= pend_d;
         bit_q    <= bit_d;
         load_q   <= load_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign tx_bit    = bit_q;
   assign tx_load   = load_q;
   assign tx_busy   = busy_q;
   assign tx_done   = done_q;
   assign tx_err    = err_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_phi_readout_tx.sv
// Directed bench for phi_readout_tx: frame-queue reference model checked every
// cycle, plus hand-computed latency, length and bit-content expectations.
`timescale 1ns/1ps
module tb_phi_readout_tx;
   import onn_pkg::*;

   localparam int W  = 60;
`ifdef PHI_TX_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif
   localparam int SC = 4;

   localparam logic [0:W-1] P1 = 60'hFFFF5FF1FFF5FFF;
   localparam logic [0:W-1] P2 = 60'h123456789ABCDEF;
   localparam logic [0:W-1] P3 = 60'hA5C3_0F96_E71B_2D4;
   localparam logic [0:W-1] P4 = 60'hFFFFFFFFFFFFFFF;

   // clock / reset / DUT
   logic          sclk = 1'b0;
   logic          re_n = 1'b0;
   logic          tx_req = 1'b0;
   logic          steady = 1'b0;
   logic          inconsistant = 1'b0;
   logic [0:W-1]  phi_in = '0;
   logic          tx_bit, tx_load, tx_busy, tx_done, tx_err;
   tx_state_e     state_dbg;

   always #5 sclk = ~sclk;

   phi_readout_tx #(.STABLE_CYC(SC)) dut (
      .sclk        (sclk),
      .re_n        (re_n),
      .tx_req      (tx_req),
      .steady      (steady),
      .inconsistant(inconsistant),
      .phi_in      (phi_in),
      .tx_bit      (tx_bit),
      .tx_load     (tx_load),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_err      (tx_err),
      .state_dbg   (state_dbg)
   );

   // scoreboard counters
   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // reference model: a frame is a queue of bits emitted one per cycle
   logic exp_q[$];
   int   m_mode = 0;   // 0 idle, 1 waiting for stability, 2 sending
   int   m_run  = 0;
   bit   m_pend = 0;
   logic e_bit = 0, e_load = 0, e_busy = 0, e_done = 0, e_err = 0;

   always @(posedge sclk or negedge re_n) begin
      if (!re_n) begin
         m_mode = 0; m_run = 0; m_pend = 0;
         exp_q.delete();
         e_bit = 0; e_load = 0; e_busy = 0; e_done = 0; e_err = 0;
      end else begin
         e_bit = 0; e_load = 0; e_done = 0; e_err = 0;
         case (m_mode)
            0: if (tx_req) begin m_mode = 1; m_run = 0; end
            1: begin
               if (inconsistant) begin
                  e_err = 1; m_mode = 0;
               end else if (steady) begin
                  m_run++;
                  if (m_run == SC) begin
                     for (int i = 0; i < W; i++) exp_q.push_back(phi_in[i]);
`ifdef PHI_TX_PARITY_EN
                     exp_q.push_back(logic'($countones(phi_in) % 2));
`endif
                     e_bit = exp_q.pop_front();
                     e_load = 1;
                     m_mode = 2;
                  end
               end else begin
                  m_run = 0;
               end
            end
            default: begin
               if (tx_req) m_pend = 1;
               if (exp_q.size() > 0) begin
                  e_bit = exp_q.pop_front();
                  e_load = 1;
               end else begin
                  e_done = 1;
                  m_mode = m_pend ? 1 : 0;
                  m_run = 0;
                  m_pend = 0;
               end
            end
         endcase
         e_busy = (m_mode != 0);
      end
   end

   // per-cycle compare and frame monitor
   logic cap [0:FL-1];
   int   ncap = 0, first_load = -1, frames = 0, busy_rise = 0, done_cnt = 0, err_cnt = 0;
   logic prev_load = 0, prev_busy = 0;

   always @(posedge sclk) begin
      cyc <= cyc + 1;
      #1;
      check("tx_load", tx_load, e_load);
      check("tx_bit",  tx_bit,  e_bit);
      check("tx_busy", tx_busy, e_busy);
      check("tx_done", tx_done, e_done);
      check("tx_err",  tx_err,  e_err);
      if (tx_load === 1'b1) begin
         if (ncap == 0) first_load = cyc;
         if (ncap < FL) cap[ncap] = tx_bit;
         ncap++;
      end
      if (tx_load === 1'b1 && !prev_load) frames++;
      if (tx_busy === 1'b1 && !prev_busy) busy_rise++;
      if (tx_done === 1'b1) done_cnt++;
      if (tx_err === 1'b1) err_cnt++;
      prev_load = tx_load;
      prev_busy = tx_busy;
   end

   // driver tasks
   int req_cyc = 0;

   task automatic clear_mon();
      ncap = 0; first_load = -1; frames = 0; busy_rise = 0; done_cnt = 0; err_cnt = 0;
   endtask

   task automatic pulse_req();
      @(negedge sclk);
      tx_req = 1'b1;
      @(posedge sclk);
      #2;
      req_cyc = cyc;
      @(negedge sclk);
      tx_req = 1'b0;
   endtask

   task automatic wait_done(input string name, input int n, input int budget);
      int k = 0;
      while (done_cnt < n && k < budget) begin
         @(negedge sclk);
         k++;
      end
      check(name, done_cnt >= n, 1);
   endtask

   task automatic wait_cap(input string name, input int n, input int budget);
      int k = 0;
      while (ncap < n && k < budget) begin
         @(negedge sclk);
         k++;
      end
      check(name, ncap >= n, 1);
   endtask

   function automatic logic [W-1:0] cap_word();
      logic [0:W-1] w;
      for (int i = 0; i < W; i++) w[i] = cap[i];
      return w;
   endfunction

   initial begin
      int steady_seq [7] = '{1, 1, 0, 1, 1, 1, 1};

      // 1: reset, then a single request with steady already high
      steady = 1'b1;
      phi_in = P1;
      repeat (3) @(negedge sclk);
      check("rst_busy", tx_busy, 0);
      check("rst_load", tx_load, 0);
      re_n = 1'b1;
      clear_mon();
      pulse_req();
      wait_done("t1_timeout", 1, 200);
      repeat (3) @(negedge sclk);
      check("t1_latency", first_load - req_cyc, SC);
      check("t1_len", ncap, FL);
      check("t1_bits", cap_word(), P1);
      check("t1_done", done_cnt, 1);
      check("t1_frames", frames, 1);

      // 2: steady glitch delays capture; phi_in change mid-frame is ignored
      steady = 1'b0;
      phi_in = P2;
      clear_mon();
      pulse_req();
      for (int i = 0; i < 7; i++) begin
         steady = logic'(steady_seq[i]);
         @(negedge sclk);
      end
      repeat (10) @(negedge sclk);
      phi_in = '0;
      steady = 1'b0;
      inconsistant = 1'b1;
      wait_done("t2_timeout", 1, 200);
      inconsistant = 1'b0;
      repeat (2) @(negedge sclk);
      check("t2_latency", first_load - req_cyc, 7);
      check("t2_bits", cap_word(), P2);
      check("t2_err", err_cnt, 0);

      // 3a: abort while not yet stable
      steady = 1'b0;
      phi_in = P3;
      clear_mon();
      pulse_req();
      inconsistant = 1'b1;
      @(negedge sclk);
      inconsistant = 1'b0;
      repeat (3) @(negedge sclk);
      check("t3a_err", err_cnt, 1);
      check("t3a_noload", ncap, 0);
      check("t3a_busy", tx_busy, 0);

      // 3b: abort on the edge that would otherwise capture
      steady = 1'b1;
      clear_mon();
      pulse_req();
      repeat (3) @(negedge sclk);
      inconsistant = 1'b1;
      @(negedge sclk);
      inconsistant = 1'b0;
      repeat (3) @(negedge sclk);
      check("t3b_err", err_cnt, 1);
      check("t3b_noload", ncap, 0);
      check("t3b_busy", tx_busy, 0);

      // 4: two requests during SHIFT give exactly one more frame
      clear_mon();
      pulse_req();
      wait_cap("t4_cap_timeout", 10, 100);
      tx_req = 1'b1;
      @(negedge sclk);
      tx_req = 1'b0;
      repeat (5) @(negedge sclk);
      tx_req = 1'b1;
      @(negedge sclk);
      tx_req = 1'b0;
      wait_done("t4_timeout", 2, 400);
      repeat (10) @(negedge sclk);
      check("t4_done", done_cnt, 2);
      check("t4_frames", frames, 2);
      check("t4_busy_rise", busy_rise, 1);
      check("t4_len", ncap, 2 * FL);
      check("t4_idle", tx_busy, 0);

      // 5: asynchronous reset mid-frame
      phi_in = P4;
      clear_mon();
      pulse_req();
      wait_cap("t5_cap_timeout", 30, 100);
      @(posedge sclk);
      #3;
      check("t5_pre_load", tx_load, 1);
      check("t5_pre_bit", tx_bit, 1);
      re_n = 1'b0;
      #1;
      check("t5_load", tx_load, 0);
      check("t5_bit", tx_bit, 0);
      check("t5_busy", tx_busy, 0);
      repeat (2) @(negedge sclk);
      re_n = 1'b1;
      clear_mon();
      repeat (80) @(negedge sclk);
      check("t5_nodone", done_cnt, 0);
      check("t5_noload", ncap, 0);
      check("t5_idle", tx_busy, 0);

`ifdef PHI_TX_PARITY_EN
      // 6: parity bit for odd and even ones counts
      phi_in = 60'h7F;
      clear_mon();
      pulse_req();
      wait_done("t6a_timeout", 1, 200);
      repeat (2) @(negedge sclk);
      check("t6a_len", ncap, 61);
      check("t6a_par", cap[W], 1);
      phi_in = 60'h3F;
      clear_mon();
      pulse_req();
      wait_done("t6b_timeout", 1, 200);
      repeat (2) @(negedge sclk);
      check("t6b_len", ncap, 61);
      check("t6b_par", cap[W], 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=%0t exp=<500000", $time);
      $fatal(1, "timeout");
   end

endmodule
